// File: rtl/sdr_arb_pkg.sv
// Shared types and defaults for the SDRAM application-port arbiter.
package sdr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_e;

  localparam int DEF_NREQ   = 2;
  localparam int DEF_APP_AW = 26;
  localparam int DEF_BL     = 9;
  localparam int DEF_DW     = 32;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdr_rr_pick.sv
// Combinational round-robin selector: first asserted request after last_grant, wrapping.
module sdr_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_valid
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sdr_app_arbiter.sv
// Round-robin arbiter sharing the sdrc_core application port between NREQ clients,
// holding each grant for a whole write or read burst.
module sdr_app_arbiter
  import sdr_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int APP_AW = DEF_APP_AW,
  parameter int bl     = DEF_BL,
  parameter int dw     = DEF_DW
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_resetn,
  input  logic                   sdr_init_done,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*APP_AW-1:0] req_addr_i,
  input  logic [NREQ*bl-1:0]     req_len_i,
  input  logic [NREQ-1:0]        req_wr_n_i,
  output logic [NREQ-1:0]        req_ack_o,
  input  logic [NREQ*dw-1:0]     wr_data_i,
  input  logic [NREQ*dw/8-1:0]   wr_en_n_i,
  output logic [NREQ-1:0]        wr_next_o,
  output logic [dw-1:0]          rd_data_o,
  output logic [NREQ-1:0]        rd_valid_o,
  output logic [NREQ-1:0]        last_rd_o,
  output logic                   busy_o,
  output logic                   app_req,
  output logic [APP_AW-1:0]      app_req_addr,
  output logic [bl-1:0]          app_req_len,
  output logic                   app_req_wr_n,
  input  logic                   app_req_ack,
  output logic [dw-1:0]          app_wr_data,
  output logic [dw/8-1:0]        app_wr_en_n,
  input  logic                   app_wr_next_req,
  input  logic [dw-1:0]          app_rd_data,
  input  logic                   app_rd_valid,
  input  logic                   app_last_rd
);

  localparam int IW = idx_width(NREQ);
  localparam int BE = dw / 8;

  arb_state_e    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [bl-1:0] beat_cnt;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  sdr_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_i),
    .last_grant (last_grant),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // last_grant resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= IW'(NREQ - 1);
      beat_cnt     <= '0;
      app_req      <= 1'b0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sdr_init_done && pick_valid) begin
            grant        <= pick_idx;
            app_req      <= 1'b1;
            app_req_addr <= req_addr_i[pick_idx*APP_AW +: APP_AW];
            app_req_len  <= req_len_i[pick_idx*bl +: bl];
            app_req_wr_n <= req_wr_n_i[pick_idx];
            state        <= REQ;
          end
        end
        REQ: begin
          if (app_req_ack) begin
            app_req    <= 1'b0;
            beat_cnt   <= app_req_len;
            last_grant <= grant;
            if (app_req_wr_n)
              state <= RDATA;
            else if (app_req_len == '0)
              state <= IDLE;
            else
              state <= WDATA;
          end
        end
        // Exit on the beat that takes the count from 1, so beat_cnt never wraps.
        WDATA: begin
          if (app_wr_next_req) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == bl'(1)) state <= IDLE;
          end
        end
        RDATA: begin
          if (app_rd_valid && app_last_rd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ack_o   = '0;
    wr_next_o   = '0;
    rd_valid_o  = '0;
    last_rd_o   = '0;
    app_wr_data = wr_data_i[grant*dw +: dw];
    app_wr_en_n = '1;
    case (state)
      REQ:   req_ack_o[grant] = app_req_ack;
      WDATA: begin
        wr_next_o[grant] = app_wr_next_req;
        app_wr_en_n      = wr_en_n_i[grant*BE +: BE];
      end
      RDATA: begin
        rd_valid_o[grant] = app_rd_valid;
        last_rd_o[grant]  = app_rd_valid & app_last_rd;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state != IDLE);
  assign rd_data_o = app_rd_data;

endmodule

// File: tb/tb_sdr_app_arbiter.sv
// Directed bench for sdr_app_arbiter: a per-cycle vector table plus hand-written burst sequences.
module tb_sdr_app_arbiter;

  localparam int NREQ   = 2;
  localparam int APP_AW = 26;
  localparam int BL     = 9;
  localparam int DW     = 32;
  localparam int BE     = DW / 8;

  logic                   sdram_clk = 1'b0;
  logic                   sdram_resetn;
  logic                   sdr_init_done;
  logic [NREQ-1:0]        req_i;
  logic [NREQ*APP_AW-1:0] req_addr_i;
  logic [NREQ*BL-1:0]     req_len_i;
  logic [NREQ-1:0]        req_wr_n_i;
  logic [NREQ-1:0]        req_ack_o;
  logic [NREQ*DW-1:0]     wr_data_i;
  logic [NREQ*BE-1:0]     wr_en_n_i;
  logic [NREQ-1:0]        wr_next_o;
  logic [DW-1:0]          rd_data_o;
  logic [NREQ-1:0]        rd_valid_o;
  logic [NREQ-1:0]        last_rd_o;
  logic                   busy_o;
  logic                   app_req;
  logic [APP_AW-1:0]      app_req_addr;
  logic [BL-1:0]          app_req_len;
  logic                   app_req_wr_n;
  logic                   app_req_ack;
  logic [DW-1:0]          app_wr_data;
  logic [BE-1:0]          app_wr_en_n;
  logic                   app_wr_next_req;
  logic [DW-1:0]          app_rd_data;
  logic                   app_rd_valid;
  logic                   app_last_rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [APP_AW-1:0] exp_addr [NREQ];
  logic [DW-1:0]     exp_data [NREQ];

  typedef struct {
    logic [1:0] req;
    logic       ack;
    logic       wnext;
    logic       rvalid;
    logic       rlast;
    logic       exp_app_req;
    logic [1:0] exp_ack;
    logic [1:0] exp_wnext;
    logic [1:0] exp_rvalid;
    logic [1:0] exp_last;
    logic       exp_busy;
    logic [3:0] exp_wen;
  } vec_t;

  vec_t vecs[$];

  sdr_app_arbiter #(
    .NREQ   (NREQ),
    .APP_AW (APP_AW),
    .bl     (BL),
    .dw     (DW)
  ) dut (
    .sdram_clk       (sdram_clk),
    .sdram_resetn    (sdram_resetn),
    .sdr_init_done   (sdr_init_done),
    .req_i           (req_i),
    .req_addr_i      (req_addr_i),
    .req_len_i       (req_len_i),
    .req_wr_n_i      (req_wr_n_i),
    .req_ack_o       (req_ack_o),
    .wr_data_i       (wr_data_i),
    .wr_en_n_i       (wr_en_n_i),
    .wr_next_o       (wr_next_o),
    .rd_data_o       (rd_data_o),
    .rd_valid_o      (rd_valid_o),
    .last_rd_o       (last_rd_o),
    .busy_o          (busy_o),
    .app_req         (app_req),
    .app_req_addr    (app_req_addr),
    .app_req_len     (app_req_len),
    .app_req_wr_n    (app_req_wr_n),
    .app_req_ack     (app_req_ack),
    .app_wr_data     (app_wr_data),
    .app_wr_en_n     (app_wr_en_n),
    .app_wr_next_req (app_wr_next_req),
    .app_rd_data     (app_rd_data),
    .app_rd_valid    (app_rd_valid),
    .app_last_rd     (app_last_rd)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Every cycle step lands 1ns after the rising edge; inputs are driven there.
  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [APP_AW-1:0] addr, input logic [BL-1:0] len,
                         input logic wr_n, input logic [DW-1:0] data, input logic [BE-1:0] ben_n);
    req_addr_i[k*APP_AW +: APP_AW] = addr;
    req_len_i[k*BL +: BL]          = len;
    req_wr_n_i[k]                  = wr_n;
    wr_data_i[k*DW +: DW]          = data;
    wr_en_n_i[k*BE +: BE]          = ben_n;
    exp_addr[k]                    = addr;
    exp_data[k]                    = data;
  endtask

  task automatic add_vec(input logic [1:0] req, input logic ack, input logic wnext, input logic rvalid,
                         input logic rlast, input logic e_req, input logic [1:0] e_ack,
                         input logic [1:0] e_wnext, input logic [1:0] e_rvalid, input logic [1:0] e_last,
                         input logic e_busy, input logic [3:0] e_wen);
    vec_t v;
    v = '{req, ack, wnext, rvalid, rlast, e_req, e_ack, e_wnext, e_rvalid, e_last, e_busy, e_wen};
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v, input int i);
    req_i           = v.req;
    app_req_ack     = v.ack;
    app_wr_next_req = v.wnext;
    app_rd_valid    = v.rvalid;
    app_last_rd     = v.rlast;
    app_rd_data     = 32'hD000_0000 + DW'(i);
  endtask

  // Acts as the controller for one burst by requester idx; returns cycles spent waiting for app_req.
  task automatic serve_burst(input int idx, input logic is_wr, input int beats_exp, output int wait_cycles);
    logic [NREQ-1:0] oh;
    int              beats;
    logic            saw_last;
    oh          = NREQ'(1 << idx);
    wait_cycles = 0;
    while (!app_req && wait_cycles < 50) begin
      step();
      #1;
      wait_cycles++;
    end
    check_output("app_req_seen", 64'(app_req), 64'd1);
    check_output("app_req_addr", 64'(app_req_addr), 64'(exp_addr[idx]));
    check_output("app_req_len", 64'(app_req_len), 64'(beats_exp));
    check_output("app_req_wr_n", 64'(app_req_wr_n), 64'(!is_wr));
    app_req_ack = 1'b1;
    #1;
    check_output("req_ack_o", 64'(req_ack_o), 64'(oh));
    step();
    app_req_ack = 1'b0;
    beats    = 0;
    saw_last = 1'b0;
    for (int g = 0; g < 600; g++) begin
      if (is_wr) app_wr_next_req = 1'b1;
      else begin
        app_rd_valid = 1'b1;
        app_last_rd  = (beats == beats_exp - 1);
      end
      #1;
      if (!busy_o) break;
      if (is_wr && wr_next_o == oh) begin
        if (beats == 0) check_output("app_wr_data", 64'(app_wr_data), 64'(exp_data[idx]));
        beats++;
      end
      if (!is_wr && rd_valid_o == oh) begin
        beats++;
        saw_last = (last_rd_o == oh);
      end
      step();
    end
    app_wr_next_req = 1'b0;
    app_rd_valid    = 1'b0;
    app_last_rd     = 1'b0;
    check_output("beat_count", 64'(beats), 64'(beats_exp));
    if (!is_wr) check_output("last_rd_seen", 64'(saw_last), 64'd1);
    check_output("idle_gap_app_req", 64'(app_req), 64'd0);
  endtask

  initial begin
    int wc;

    sdram_resetn    = 1'b0;
    sdr_init_done   = 1'b1;
    req_i           = 2'b11;
    req_addr_i      = '0;
    req_len_i       = '0;
    req_wr_n_i      = '1;
    wr_data_i       = '0;
    wr_en_n_i       = '1;
    app_req_ack     = 1'b1;
    app_wr_next_req = 1'b1;
    app_rd_valid    = 1'b1;
    app_last_rd     = 1'b1;
    app_rd_data     = '0;

    // Reset values, with every input pushing against them.
    repeat (3) step();
    #1;
    check_output("rst_app_req", 64'(app_req), 64'd0);
    check_output("rst_app_req_addr", 64'(app_req_addr), 64'd0);
    check_output("rst_app_req_len", 64'(app_req_len), 64'd0);
    check_output("rst_app_req_wr_n", 64'(app_req_wr_n), 64'd1);
    check_output("rst_req_ack_o", 64'(req_ack_o), 64'd0);
    check_output("rst_wr_next_o", 64'(wr_next_o), 64'd0);
    check_output("rst_rd_valid_o", 64'(rd_valid_o), 64'd0);
    check_output("rst_last_rd_o", 64'(last_rd_o), 64'd0);
    check_output("rst_busy_o", 64'(busy_o), 64'd0);
    check_output("rst_app_wr_en_n", 64'(app_wr_en_n), 64'hF);

    req_i           = '0;
    app_req_ack     = 1'b0;
    app_wr_next_req = 1'b0;
    app_rd_valid    = 1'b0;
    app_last_rd     = 1'b0;
    set_req(0, 26'h100, 9'd4, 1'b0, 32'hA0A0_0001, 4'b0101);
    set_req(1, 26'h2000, 9'd3, 1'b1, 32'hB1B1_0002, 4'b1010);
    step();
    sdram_resetn = 1'b1;

    // Single write (req 0, len 4, ack after 3 REQ cycles) then read on req 1 (len 3).
    //      req    ack   wnx   rv    rl    e_req e_ack  e_wnx  e_rv   e_last busy  wen
    add_vec(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'hF);
    add_vec(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'hF);
    add_vec(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'hF);
    add_vec(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'hF);
    add_vec(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 4'hF);
    add_vec(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4'h5);
    add_vec(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'h5);
    add_vec(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4'h5);
    add_vec(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4'h5);
    add_vec(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4'h5);
    add_vec(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'hF);
    add_vec(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'hF);
    add_vec(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 4'hF);
    add_vec(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 4'hF);
    add_vec(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'hF);
    add_vec(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 4'hF);
    add_vec(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 4'hF);
    add_vec(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'hF);

    foreach (vecs[i]) begin
      step();
      apply_stimulus(vecs[i], i);
      #1;
      check_output($sformatf("v%0d_app_req", i), 64'(app_req), 64'(vecs[i].exp_app_req));
      check_output($sformatf("v%0d_req_ack_o", i), 64'(req_ack_o), 64'(vecs[i].exp_ack));
      check_output($sformatf("v%0d_wr_next_o", i), 64'(wr_next_o), 64'(vecs[i].exp_wnext));
      check_output($sformatf("v%0d_rd_valid_o", i), 64'(rd_valid_o), 64'(vecs[i].exp_rvalid));
      check_output($sformatf("v%0d_last_rd_o", i), 64'(last_rd_o), 64'(vecs[i].exp_last));
      check_output($sformatf("v%0d_busy_o", i), 64'(busy_o), 64'(vecs[i].exp_busy));
      check_output($sformatf("v%0d_app_wr_en_n", i), 64'(app_wr_en_n), 64'(vecs[i].exp_wen));
      check_output($sformatf("v%0d_rd_data_o", i), 64'(rd_data_o), 64'(32'hD000_0000 + DW'(i)));
    end
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;

    // Contention: both hold requests; grants must alternate with one idle cycle between.
    set_req(0, 26'h110, 9'd2, 1'b0, 32'hA0A0_0011, 4'b0000);
    set_req(1, 26'h2110, 9'd2, 1'b0, 32'hB1B1_0022, 4'b0011);
    req_i = 2'b11;
    for (int b = 0; b < 4; b++) begin
      serve_burst(b % 2, 1'b1, 2, wc);
      if (b > 0) check_output($sformatf("b2b_wait%0d", b), 64'(wc), 64'd1);
    end
    req_i = '0;

    // Init gating: no grant while sdr_init_done is low, grant one cycle after it rises.
    sdr_init_done = 1'b0;
    set_req(0, 26'h400, 9'd1, 1'b0, 32'hA0A0_0400, 4'b0000);
    req_i = 2'b01;
    for (int c = 0; c < 20; c++) begin
      step();
      #1;
      check_output($sformatf("init_gate%0d", c), 64'(app_req), 64'd0);
    end
    sdr_init_done = 1'b1;
    step();
    #1;
    check_output("init_latency", 64'(app_req), 64'd1);
    serve_burst(0, 1'b1, 1, wc);
    req_i = '0;

    // Asynchronous reset two beats into an 8-beat write.
    set_req(0, 26'h300, 9'd8, 1'b0, 32'hA0A0_0300, 4'b0110);
    req_i = 2'b01;
    wc = 0;
    while (!app_req && wc < 50) begin
      step();
      #1;
      wc++;
    end
    check_output("rstmid_app_req", 64'(app_req), 64'd1);
    app_req_ack = 1'b1;
    step();
    app_req_ack     = 1'b0;
    req_i           = '0;
    app_wr_next_req = 1'b1;
    step();
    #1;
    check_output("rstmid_busy_before", 64'(busy_o), 64'd1);
    check_output("rstmid_wnext_before", 64'(wr_next_o), 64'b01);
    step();
    sdram_resetn = 1'b0;
    #1;
    check_output("rstmid_app_req_low", 64'(app_req), 64'd0);
    check_output("rstmid_busy", 64'(busy_o), 64'd0);
    check_output("rstmid_wr_next_o", 64'(wr_next_o), 64'd0);
    check_output("rstmid_app_wr_en_n", 64'(app_wr_en_n), 64'hF);
    check_output("rstmid_app_req_wr_n", 64'(app_req_wr_n), 64'd1);
    check_output("rstmid_app_req_addr", 64'(app_req_addr), 64'd0);
    check_output("rstmid_app_req_len", 64'(app_req_len), 64'd0);
    app_wr_next_req = 1'b0;
    set_req(0, 26'h310, 9'd1, 1'b0, 32'hA0A0_0310, 4'b0000);
    set_req(1, 26'h2310, 9'd1, 1'b0, 32'hB1B1_0310, 4'b0000);
    req_i = 2'b11;
    step();
    step();
    sdram_resetn = 1'b1;
    #1;
    serve_burst(0, 1'b1, 1, wc);
    req_i = '0;

    // Edge lengths: zero-length write, then the maximum 511-beat write.
    set_req(1, 26'h500, 9'd0, 1'b0, 32'hB1B1_0500, 4'b0000);
    req_i = 2'b10;
    serve_burst(1, 1'b1, 0, wc);
    req_i = '0;
    set_req(0, 26'h600, 9'd511, 1'b0, 32'hA0A0_0600, 4'b1100);
    req_i = 2'b01;
    serve_burst(0, 1'b1, 511, wc);
    req_i = '0;

    repeat (2) step();
    $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
